fetch_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 29 ++
 rtl/next_pc_calc.sv | 36 +++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and field positions for the MIPS fetch stage
package mips_pkg;

  // next-PC select, sampled together with retire
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_REG    = 2'b11
  } pc_src_e;

  // fetch sequencer states
  typedef enum logic [1:0] {
    ST_REQ   = 2'b00,
    ST_HOLD  = 2'b01,
    ST_FAULT = 2'b10
  } fetch_state_e;

  // instruction field bit positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM16_MSB  = 15;
  localparam int IMM16_LSB  = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection and alignment check
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic [31:0] reg_target,
  input  logic [1:0]  pc_src,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] branch_off;
  logic        unused_opcode_bits;

  // word offset: sign-extended imm16 shifted left by two
  assign branch_off = {{14{instr[IMM16_MSB]}}, instr[IMM16_MSB:IMM16_LSB], 2'b00};

  // opcode bits are not needed to form any target
  assign unused_opcode_bits = ^instr[OPCODE_MSB:OPCODE_LSB];

  // select the target named by pc_src
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src_e'(pc_src))
      PC_SEQ:    next_pc = pc_plus4;
      PC_BRANCH: next_pc = pc_plus4 + branch_off;
      PC_JUMP:   next_pc = {pc_plus4[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};
      PC_REG:    next_pc = reg_target;
      default:   next_pc = pc_plus4;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction fetch stage: PC, imem handshake, instruction hold
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        retire,
  input  logic [1:0]  pc_src,
  input  logic [31:0] reg_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count,
  output logic        fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  next_pc;
  logic         misaligned;
  logic         take_ack;
  logic         take_retire;

  next_pc_calc u_next_pc_calc (
    .pc_plus4   (pc_plus4),
    .instr      (instr),
    .reg_target (reg_target),
    .pc_src     (pc_src),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;
  assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];
  assign funct       = instr[FUNCT_MSB:FUNCT_LSB];
  assign take_ack    = (state_q == ST_REQ) && imem_ack;
  assign take_retire = (state_q == ST_HOLD) && retire;

  // fetch state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and per-state outputs; request is gated by rst_n so it drops as reset asserts
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    case (state_q)
      ST_REQ: begin
        imem_req = rst_n;
        if (imem_ack) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        instr_valid = 1'b1;
        if (retire) begin
          state_d = misaligned ? ST_FAULT : ST_REQ;
        end
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // instruction capture, PC advance and retire counting; a misaligned target leaves pc alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_count <= 32'h0;
    end else begin
      if (take_ack) begin
        instr <= imem_rdata;
      end
      if (take_retire) begin
        instr_count <= instr_count + 32'd1;
        if (!misaligned) begin
          pc <= next_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        retire;
  logic [1:0]  pc_src;
  logic [31:0] reg_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr_count;
  logic        fault;

  int n_total;
  int n_pass;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .retire      (retire),
    .pc_src      (pc_src),
    .reg_target  (reg_target),
    .instr_valid (instr_valid),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_count (instr_count),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          waits;
    logic [1:0]  src;
    logic [31:0] target;
    logic [31:0] next_pc;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    retire = 1'b0;
    pc_src = 2'b00;
    reg_target = 32'h0;
    repeat (2) tick();
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_count", instr_count, 32'h0);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic fetch_retire(input logic [31:0] word, input logic [1:0] src, input logic [31:0] tgt);
    imem_ack = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    retire = 1'b1;
    pc_src = src;
    reg_target = tgt;
    tick();
    retire = 1'b0;
  endtask

  // reference next-PC from the architectural rules
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                              input logic [1:0] src, input logic [31:0] tgt);
    logic [31:0] p4;
    shortint     imm;
    logic [31:0] off;
    p4  = cur_pc + 32'd4;
    imm = ins[15:0];
    off = 32'(imm) * 32'd4;
    case (src)
      2'd0:    return p4;
      2'd1:    return p4 + off;
      2'd2:    return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
      default: return tgt;
    endcase
  endfunction

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] w;
    logic        m_hold;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_count;
    logic [31:0] r;

    n_total = 0;
    n_pass  = 0;

    vecs[0] = '{32'h2008_0005, 3, 2'b00, 32'h0,         32'h0000_0004};
    vecs[1] = '{32'h03E0_0008, 1, 2'b11, 32'h0000_0010, 32'h0000_0010};
    vecs[2] = '{32'h1000_FFFE, 0, 2'b01, 32'h0,         32'h0000_000C};
    vecs[3] = '{32'h03E0_0008, 2, 2'b11, 32'h0000_0010, 32'h0000_0010};
    vecs[4] = '{32'h1000_0003, 0, 2'b01, 32'h0,         32'h0000_0020};
    vecs[5] = '{32'h0120_0009, 1, 2'b11, 32'hF000_0000, 32'hF000_0000};
    vecs[6] = '{32'h0800_0100, 0, 2'b10, 32'h0,         32'hF000_0400};
    vecs[7] = '{32'h1120_8000, 2, 2'b01, 32'h0,         32'hEFFE_0404};
    vecs[8] = '{32'h8C22_0004, 0, 2'b00, 32'h0,         32'hEFFE_0408};

    // table-driven fetch/retire sequence from reset
    apply_reset();
    exp_pc = 32'h0;
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < vecs[i].waits; k++) begin
        chk("wait_req", {31'h0, imem_req}, 32'h1);
        chk("wait_addr", imem_addr, exp_pc);
        tick();
      end
      chk("ack_req", {31'h0, imem_req}, 32'h1);
      chk("ack_addr", imem_addr, exp_pc);
      imem_ack = 1'b1;
      imem_rdata = vecs[i].word;
      tick();
      imem_ack = 1'b0;
      w = vecs[i].word;
      chk("hold_valid", {31'h0, instr_valid}, 32'h1);
      chk("hold_req", {31'h0, imem_req}, 32'h0);
      chk("hold_instr", instr, w);
      chk("hold_opcode", {26'h0, opcode}, {26'h0, w[31:26]});
      chk("hold_funct", {26'h0, funct}, {26'h0, w[5:0]});
      chk("hold_pc_plus4", pc_plus4, exp_pc + 32'd4);
      if (i == 0) chk("first_opcode_addi", {26'h0, opcode}, 32'h0000_0008);
      retire = 1'b1;
      pc_src = vecs[i].src;
      reg_target = vecs[i].target;
      tick();
      retire = 1'b0;
      exp_pc = vecs[i].next_pc;
      chk("ret_pc", pc, exp_pc);
      chk("ret_req", {31'h0, imem_req}, 32'h1);
      chk("ret_valid", {31'h0, instr_valid}, 32'h0);
      chk("ret_count", instr_count, 32'(i + 1));
      chk("ret_fault", {31'h0, fault}, 32'h0);
    end

    // reset asserted while waiting in REQ, with an ack outstanding
    tick();
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_drop", {31'h0, imem_req}, 32'h0);
    chk("midrst_count", instr_count, 32'h0);
    chk("midrst_pc", pc, 32'h0);
    repeat (2) tick();
    chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
    chk("midrst_instr", instr, 32'h0);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("restart_req", {31'h0, imem_req}, 32'h1);
    chk("restart_addr", imem_addr, 32'h0);
    tick();
    chk("restart_req_held", {31'h0, imem_req}, 32'h1);
    chk("restart_count", instr_count, 32'h0);

    // misaligned register target: sticky fault, pc kept, count still advances
    apply_reset();
    fetch_retire(32'h03E0_0008, 2'b11, 32'h0000_0040);
    chk("pre_fault_pc", pc, 32'h0000_0040);
    fetch_retire(32'h0120_0009, 2'b11, 32'h0000_0102);
    for (int k = 0; k < 5; k++) begin
      chk("fault_flag", {31'h0, fault}, 32'h1);
      chk("fault_req", {31'h0, imem_req}, 32'h0);
      chk("fault_valid", {31'h0, instr_valid}, 32'h0);
      chk("fault_pc", pc, 32'h0000_0040);
      chk("fault_count", instr_count, 32'h2);
      imem_ack = 1'b1;
      retire = 1'b1;
      pc_src = 2'b00;
      tick();
    end
    imem_ack = 1'b0;
    retire = 1'b0;
    apply_reset();
    chk("fault_cleared_req", {31'h0, imem_req}, 32'h1);

    // randomized traffic against the reference model
    apply_reset();
    m_hold = 1'b0;
    m_pc = 32'h0;
    m_instr = 32'h0;
    m_count = 32'h0;
    for (int n = 0; n < 500; n++) begin
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      retire = 1'($urandom_range(0, 1));
      pc_src = 2'($urandom_range(0, 3));
      r = $urandom;
      r[1:0] = 2'b00;
      reg_target = r;
      if (!m_hold) begin
        if (imem_ack) begin
          m_instr = imem_rdata;
          m_hold = 1'b1;
        end
      end else if (retire) begin
        m_count = m_count + 32'd1;
        m_pc = model_next(m_pc, m_instr, pc_src, reg_target);
        m_hold = 1'b0;
      end
      tick();
      chk("rnd_req", {31'h0, imem_req}, {31'h0, ~m_hold});
      chk("rnd_valid", {31'h0, instr_valid}, {31'h0, m_hold});
      chk("rnd_pc", pc, m_pc);
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_instr", instr, m_instr);
      chk("rnd_count", instr_count, m_count);
      chk("rnd_fault", {31'h0, fault}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
